// File: rtl/cvxif_result_queue.sv
// Commit-gated in-order result buffer between the CV-X-IF result channel and core writeback.
// Optional zero-latency bypass when CVXIF_RESULT_BYPASS_EN is defined.
package cvxif_result_pkg;
  localparam int unsigned X_ID_WIDTH   = 3;
  localparam int unsigned X_DATA_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]   id;
    logic [X_DATA_WIDTH-1:0] data;
    logic [4:0]              rd;
    logic                    we;
    logic                    exc;
    logic [5:0]              exccode;
  } x_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;
endpackage

module cvxif_result_queue
  import cvxif_result_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_result_valid_i,
  output logic                       x_result_ready_o,
  input  x_result_t                  x_result_i,
  input  logic                       x_commit_valid_i,
  input  x_commit_t                  x_commit_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output x_result_t                  wb_result_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned SB_N  = 2**ID_WIDTH;

  x_result_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [SB_N-1:0]    r_commit;
  logic [SB_N-1:0]    r_kill;

  x_result_t          w_head;
  logic               w_nonempty;
  logic               w_head_kill;
  logic               w_head_commit;
  logic               w_ready;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic [SB_N-1:0]    w_commit_nxt;
  logic [SB_N-1:0]    w_kill_nxt;
  logic [CNT_W-1:0]   w_count_nxt;

  // Head decision: a kill outranks a commit for the same id.
  always_comb begin
    w_nonempty    = (r_count != '0);
    w_head        = r_mem[r_rd_ptr];
    w_head_kill   = w_nonempty && r_kill[w_head.id];
    w_head_commit = w_nonempty && !w_head_kill && r_commit[w_head.id];
    w_ready       = (r_count < CNT_W'(DEPTH));
`ifdef CVXIF_RESULT_BYPASS_EN
    w_bypass      = (r_count == '0) && x_result_valid_i &&
                    r_commit[x_result_i.id] && wb_ready_i;
`else
    w_bypass      = 1'b0;
`endif
    w_pop         = w_head_kill || (w_head_commit && wb_ready_i);
    w_push        = x_result_valid_i && w_ready && !w_bypass;
  end

  // Scoreboard next state: clears from pop/bypass first, then commit sets win.
  always_comb begin
    w_commit_nxt = r_commit;
    w_kill_nxt   = r_kill;
    if (w_pop) begin
      w_commit_nxt[w_head.id] = 1'b0;
      w_kill_nxt[w_head.id]   = 1'b0;
    end
    if (w_bypass) begin
      w_commit_nxt[x_result_i.id] = 1'b0;
      w_kill_nxt[x_result_i.id]   = 1'b0;
    end
    if (x_commit_valid_i) begin
      if (x_commit_i.x_commit_kill) begin
        w_kill_nxt[x_commit_i.id] = 1'b1;
      end else begin
        w_commit_nxt[x_commit_i.id] = 1'b1;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_commit <= '0;
      r_kill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count  <= w_count_nxt;
      r_commit <= w_commit_nxt;
      r_kill   <= w_kill_nxt;
    end
  end

  // Storage carries no reset; empty-queue output is forced to zero below.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= x_result_i;
    end
  end

  always_comb begin
    x_result_ready_o = w_ready;
    drop_o           = w_head_kill;
    count_o          = r_count;
    wb_valid_o       = w_head_commit || w_bypass;
    wb_result_o      = w_nonempty ? w_head : '0;
`ifdef CVXIF_RESULT_BYPASS_EN
    if (w_bypass) begin
      wb_result_o = x_result_i;
    end
`endif
  end
endmodule

// File: tb/tb_cvxif_result_queue.sv
// Directed bench for cvxif_result_queue: commit gating, ordering, kill drop, full, hold, reset.
module tb_cvxif_result_queue;
  import cvxif_result_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i;
  logic      x_result_valid_i;
  logic      x_result_ready_o;
  x_result_t x_result_i;
  logic      x_commit_valid_i;
  x_commit_t x_commit_i;
  logic      wb_valid_o;
  logic      wb_ready_i;
  x_result_t wb_result_o;
  logic      drop_o;
  logic [2:0] count_o;

  int checks = 0;
  int errors = 0;

  cvxif_result_queue #(.DEPTH(4), .ID_WIDTH(3)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_i       (x_result_i),
    .x_commit_valid_i (x_commit_valid_i),
    .x_commit_i       (x_commit_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .drop_o           (drop_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_result(input logic v, input int id, input logic [31:0] d);
    x_result_valid_i   = v;
    x_result_i         = '0;
    x_result_i.id      = 3'(id);
    x_result_i.data    = d;
    x_result_i.rd      = 5'(id + 1);
    x_result_i.we      = 1'b1;
  endtask

  task automatic set_commit(input logic v, input int id, input logic kill);
    x_commit_valid_i         = v;
    x_commit_i.id            = 3'(id);
    x_commit_i.x_commit_kill = kill;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_result(1'b0, 0, 32'h0);
    set_commit(1'b0, 0, 1'b0);
    wb_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", x_result_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b exp 0", wb_valid_o); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b exp 0", drop_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (wb_result_o !== '0) begin errors++; $display("FAIL reset_wb_result got %h exp 0", wb_result_o); end
  endtask

  task automatic test_commit_first();
    tick();
    set_commit(1'b1, 2, 1'b0);
    tick();
    set_commit(1'b0, 0, 1'b0);
    set_result(1'b1, 2, 32'h1234);
    wb_ready_i = 1'b1;
    #1;
`ifdef CVXIF_RESULT_BYPASS_EN
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL cf_bypass_valid got %0b exp 1", wb_valid_o); end
    checks++; if (wb_result_o.data !== 32'h1234) begin errors++; $display("FAIL cf_bypass_data got %h exp 1234", wb_result_o.data); end
    tick();
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL cf_bypass_count got %0d exp 0", count_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL cf_bypass_after got %0b exp 0", wb_valid_o); end
`else
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL cf_same_cycle got %0b exp 0", wb_valid_o); end
    tick();
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL cf_valid got %0b exp 1", wb_valid_o); end
    checks++; if (wb_result_o.data !== 32'h1234) begin errors++; $display("FAIL cf_data got %h exp 1234", wb_result_o.data); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL cf_count got %0d exp 1", count_o); end
    tick();
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL cf_popped got %0b exp 0", wb_valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL cf_count_end got %0d exp 0", count_o); end
`endif
    wb_ready_i = 1'b0;
  endtask

  task automatic test_ordering();
    set_result(1'b1, 0, 32'hA0);
    tick();
    set_result(1'b1, 1, 32'hA1);
    tick();
    set_result(1'b1, 2, 32'hA2);
    tick();
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL ord_count3 got %0d exp 3", count_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL ord_stall got %0b exp 0", wb_valid_o); end
    set_commit(1'b1, 1, 1'b0);
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL ord_no_reorder got %0b exp 0", wb_valid_o); end
    set_commit(1'b1, 0, 1'b0);
    wb_ready_i = 1'b1;
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o.data !== 32'hA0) begin errors++; $display("FAIL ord_first got v=%0b d=%h exp v=1 d=a0", wb_valid_o, wb_result_o.data); end
    tick();
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o.data !== 32'hA1) begin errors++; $display("FAIL ord_second got v=%0b d=%h exp v=1 d=a1", wb_valid_o, wb_result_o.data); end
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL ord_count2 got %0d exp 2", count_o); end
    tick();
    #1;
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL ord_count1 got %0d exp 1", count_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL ord_third_stall got %0b exp 0", wb_valid_o); end
    wb_ready_i = 1'b0;
    set_commit(1'b1, 2, 1'b1);
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (drop_o !== 1'b1) begin errors++; $display("FAIL ord_cleanup_drop got %0b exp 1", drop_o); end
    tick();
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL ord_cleanup_count got %0d exp 0", count_o); end
  endtask

  task automatic test_kill();
    set_result(1'b1, 5, 32'h55);
    tick();
    set_result(1'b0, 0, 32'h0);
    set_commit(1'b1, 5, 1'b1);
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (drop_o !== 1'b1) begin errors++; $display("FAIL kill_drop got %0b exp 1", drop_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL kill_no_wb got %0b exp 0", wb_valid_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL kill_count1 got %0d exp 1", count_o); end
    tick();
    #1;
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL kill_pulse_once got %0b exp 0", drop_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL kill_count0 got %0d exp 0", count_o); end
    set_result(1'b1, 5, 32'h56);
    tick();
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (drop_o !== 1'b0 || count_o !== 3'd1) begin errors++; $display("FAIL kill_bit_cleared got drop=%0b cnt=%0d exp drop=0 cnt=1", drop_o, count_o); end
    set_commit(1'b1, 5, 1'b0);
    wb_ready_i = 1'b1;
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o.data !== 32'h56) begin errors++; $display("FAIL kill_reuse_wb got v=%0b d=%h exp v=1 d=56", wb_valid_o, wb_result_o.data); end
    tick();
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL kill_reuse_count got %0d exp 0", count_o); end
    wb_ready_i = 1'b0;
  endtask

  task automatic test_full_and_hold();
    for (int i = 0; i < 4; i++) begin
      set_result(1'b1, i, 32'hB0 + 32'(i));
      tick();
    end
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (x_result_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", x_result_ready_o); end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_o); end
    set_commit(1'b1, 0, 1'b0);
    tick();
    set_commit(1'b0, 0, 1'b0);
    wb_ready_i = 1'b1;
    set_result(1'b1, 4, 32'hBF);
    #1;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL full_head_valid got %0b exp 1", wb_valid_o); end
    checks++; if (x_result_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_during_pop got %0b exp 0", x_result_ready_o); end
    tick();
    set_result(1'b0, 0, 32'h0);
    wb_ready_i = 1'b0;
    #1;
    checks++; if (x_result_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after got %0b exp 1", x_result_ready_o); end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_count_after got %0d exp 3", count_o); end
    set_commit(1'b1, 1, 1'b0);
    tick();
    set_commit(1'b0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (wb_valid_o !== 1'b1 || wb_result_o.data !== 32'hB1 || count_o !== 3'd3) begin
        errors++; $display("FAIL hold_cycle%0d got v=%0b d=%h cnt=%0d exp v=1 d=b1 cnt=3", k, wb_valid_o, wb_result_o.data, count_o);
      end
      tick();
    end
    wb_ready_i = 1'b1;
    set_commit(1'b1, 2, 1'b1);
    tick();
    set_commit(1'b1, 3, 1'b1);
    tick();
    set_commit(1'b0, 0, 1'b0);
    tick();
    tick();
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL hold_drain_count got %0d exp 0", count_o); end
    wb_ready_i = 1'b0;
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      set_result(1'b1, i, 32'hC0 + 32'(i));
      tick();
    end
    set_result(1'b0, 0, 32'h0);
    set_commit(1'b1, 0, 1'b0);
    tick();
    set_commit(1'b1, 3, 1'b0);
    tick();
    set_commit(1'b0, 0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0 || x_result_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL midrst_state got cnt=%0d rdy=%0b v=%0b exp cnt=0 rdy=1 v=0", count_o, x_result_ready_o, wb_valid_o);
    end
    set_result(1'b1, 0, 32'hD0);
    tick();
    set_result(1'b0, 0, 32'h0);
    #1;
    checks++; if (count_o !== 3'd1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_stale_commit got cnt=%0d v=%0b exp cnt=1 v=0", count_o, wb_valid_o); end
    tick();
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_still_stalled got %0b exp 0", wb_valid_o); end
    set_commit(1'b1, 0, 1'b0);
    wb_ready_i = 1'b1;
    tick();
    set_commit(1'b0, 0, 1'b0);
    #1;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o.data !== 32'hD0) begin errors++; $display("FAIL midrst_release got v=%0b d=%h exp v=1 d=d0", wb_valid_o, wb_result_o.data); end
    tick();
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL midrst_count_end got %0d exp 0", count_o); end
    wb_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit_first();
    test_ordering();
    test_kill();
    test_full_and_hold();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
